sda_kernel_control_regs: RTL
============================

# sda_kernel_control_regs

Host-facing AXI4-Lite control register block for an SDAccel kernel, directly upstream of the kernel reset handler. It implements the standard ap_ctrl/interrupt register map and the kernel argument registers. It converts host ap_start writes into the go handshake (regGoValid/regGoHoldoff) and consumes the done handshake (regDoneValid/regDoneStop) into ap_done/ap_idle status and an interrupt.

## Interface
- AddrWidth, 8: byte address width; must cover 0x10 + 8*ArgCount.
- ArgCount, 4: number of 64-bit kernel arguments (1..30).
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_axi_control_awvalid/awready  in/out  1  write address handshake
- s_axi_control_awaddr  in  AddrWidth  write byte address; bits [1:0] ignored
- s_axi_control_wvalid/wready  in/out  1  write data handshake
- s_axi_control_wdata  in  32  write data
- s_axi_control_wstrb  in  4  byte strobes
- s_axi_control_bvalid/bready  out/in  1  write response handshake
- s_axi_control_bresp  out  2  always 2'b00
- s_axi_control_arvalid/arready  in/out  1  read address handshake
- s_axi_control_araddr  in  AddrWidth  read byte address
- s_axi_control_rvalid/rready  out/in  1  read data handshake
- s_axi_control_rdata  out  32  read data
- s_axi_control_rresp  out  2  always 2'b00
- regGoValid  out  1  go request to reset handler
- regGoHoldoff  in  1  go holdoff from reset handler
- regDoneValid  in  1  done notification from reset handler
- regDoneStop  out  1  done holdoff to reset handler
- kernelArgs  out  64*ArgCount  argument n at bits [64n+63:64n]
- interrupt  out  1  level interrupt to host

## Operation
- Map: 0x00 ap_ctrl; 0x04 GIE (bit0); 0x08 IER (bit0 done, bit1 ready); 0x0C ISR (bit0 done, bit1 ready); arg n low word at 0x10+8n, high word at 0x14+8n. Unmapped: reads 0, writes dropped, OKAY response.
- ap_ctrl bits: 0 ap_start, 1 ap_done, 2 ap_idle, 3 ap_ready, 7 auto_restart (reads 0, unsupported); other bits read 0.
- Writing 1 to ap_start while idle sets startPending and clears idle; otherwise ignored. Writing 0 has no effect.
- regGoValid = startPending. Go handshake (regGoValid & ~regGoHoldoff) clears startPending.
- regDoneStop = doneFlag. Done handshake (regDoneValid & ~regDoneStop) sets doneFlag and idle, and sets ISR bits 0/1 where the matching IER bit is 1.
- ap_done and ap_ready both read doneFlag; doneFlag clears on accepted read of 0x00. If set and clear coincide, set wins.
- ISR: write 1 toggles the bit (wstrb[0] required). interrupt = GIE & |ISR, registered.
- Arg writes honour wstrb per byte; dropped while not idle. Control writes use wstrb[0] only.

## Timing
- Reset values: bvalid 0, rvalid 0, rdata 0, regGoValid 0, regDoneStop 0, interrupt 0, kernelArgs 0, GIE/IER/ISR 0, idle 1, doneFlag 0.
- awready = wready = awvalid & wvalid & ~bvalid (combinational); address and data accepted in the same cycle only.
- Write accepted at cycle N: register, regGoValid and kernelArgs update at N+1; bvalid rises at N+1 and holds until bready.
- arready = ~rvalid. Read accepted at N: rdata valid with rvalid at N+1, held stable until rready. Clear-on-read takes effect at N+1.
- Done handshake at M: ap_done readable and interrupt asserted at M+1.
- Concurrent read and write are independent. A read of 0x00 in the cycle a write sets ap_start returns pre-write state.
- Reset mid-transaction aborts it: no bvalid/rvalid is issued, and startPending and doneFlag are lost.

## Structure
- Package sda_kernel_control_pkg: offset constants (ApCtrlAddr, GieAddr, IerAddr, IsrAddr, ArgBaseAddr), ap_ctrl bit indices, response code OKAY.
- Sub-module sda_kernel_arg_reg: one 64-bit byte-strobed argument register with write enable and async reset, generated ArgCount times.

## Test plan
- Reset then read 0x00: rdata = 0x00000004; interrupt 0; kernelArgs 0.
- Write 0x10 = 0xDEADBEEF and 0x14 = 0x01234567 with wstrb 0xF, then 0x10 with wstrb 0x1 and data 0xAA: kernelArgs[63:0] = 0x01234567DEADBEAA.
- Write 0x00 = 1 with regGoHoldoff 1 for 5 cycles: regGoValid stays high; read 0x00 = 0x1. Drop holdoff: regGoValid falls next cycle; read 0x00 = 0x0.
- GIE = 1, IER = 1, then a 1-cycle regDoneValid: interrupt 1 next cycle; read 0x00 = 0xE, second read = 0x4; write ISR = 1 -> interrupt 0.
- Second regDoneValid before ap_done is read: regDoneStop 1 holds it off; after the read of 0x00, the handshake completes next cycle.
- bready held low 4 cycles after a write: awready stays 0 for the next write; bvalid is held.

Source files
------------

// File: rtl/sda_kernel_control_pkg.sv
// sda_kernel_control_pkg
// Shared constants for the SDAccel kernel control register block: the byte
// offsets of the ap_ctrl/interrupt register map, the bit positions inside
// ap_ctrl, the AXI response code, and a helper that locates each 64-bit
// kernel argument in the address map.
package sda_kernel_control_pkg;

  // Byte offsets of the fixed control registers
  localparam int unsigned ApCtrlAddr  = 32'h00;
  localparam int unsigned GieAddr     = 32'h04;
  localparam int unsigned IerAddr     = 32'h08;
  localparam int unsigned IsrAddr     = 32'h0C;
  localparam int unsigned ArgBaseAddr = 32'h10;
  localparam int unsigned ArgStride   = 32'h08;

  // Bit positions inside the ap_ctrl register
  localparam int ApStartBit     = 0;
  localparam int ApDoneBit      = 1;
  localparam int ApIdleBit      = 2;
  localparam int ApReadyBit     = 3;
  localparam int AutoRestartBit = 7;

  // Every access completes with an OKAY response, mapped or not
  localparam logic [1:0] RespOkay = 2'b00;

  // Byte address of the low word of argument n; the high word sits 4 above
  function automatic int unsigned argLoAddr(input int unsigned n);
    return ArgBaseAddr + ArgStride * n;
  endfunction

endpackage

// File: rtl/sda_kernel_arg_reg.sv
// sda_kernel_arg_reg
// One 64-bit kernel argument register written as two 32-bit words with
// per-byte strobes.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   i_wrEnLo     write the low word (bits 31:0) this cycle
//   i_wrEnHi     write the high word (bits 63:32) this cycle
//   i_wdata      32-bit write data
//   i_wstrb      byte strobes applied to whichever word is written
//   o_value      current 64-bit argument value
module sda_kernel_arg_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wrEnLo,
  input  logic        i_wrEnHi,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [63:0] o_value
);

  logic [63:0] r_value;

  // Each byte lane only changes when its strobe is set, so the host can
  // patch a single byte of an argument without a read-modify-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_wrEnLo && i_wstrb[b]) r_value[8*b +: 8]      <= i_wdata[8*b +: 8];
        if (i_wrEnHi && i_wstrb[b]) r_value[32 + 8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/sda_kernel_control_regs.sv
// sda_kernel_control_regs
// Host-facing AXI4-Lite control registers for an SDAccel kernel. Converts
// host ap_start writes into the go handshake towards the kernel reset
// handler, turns the done handshake into ap_done/ap_idle status plus an
// interrupt, and holds the 64-bit kernel argument registers.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   s_axi_control_aw*/w*/b*  AXI4-Lite write address, data and response
//   s_axi_control_ar*/r*     AXI4-Lite read address and data
//   regGoValid/regGoHoldoff  go request out, holdoff back from the handler
//   regDoneValid/regDoneStop done notification in, holdoff back out
//   kernelArgs               argument n at bits [64n+63:64n]
//   interrupt                registered level interrupt to the host
module sda_kernel_control_regs
  import sda_kernel_control_pkg::*;
#(
  parameter int AddrWidth = 8,
  parameter int ArgCount  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axi_control_awvalid,
  output logic                  s_axi_control_awready,
  input  logic [AddrWidth-1:0]  s_axi_control_awaddr,
  input  logic                  s_axi_control_wvalid,
  output logic                  s_axi_control_wready,
  input  logic [31:0]           s_axi_control_wdata,
  input  logic [3:0]            s_axi_control_wstrb,
  output logic                  s_axi_control_bvalid,
  input  logic                  s_axi_control_bready,
  output logic [1:0]            s_axi_control_bresp,
  input  logic                  s_axi_control_arvalid,
  output logic                  s_axi_control_arready,
  input  logic [AddrWidth-1:0]  s_axi_control_araddr,
  output logic                  s_axi_control_rvalid,
  input  logic                  s_axi_control_rready,
  output logic [31:0]           s_axi_control_rdata,
  output logic [1:0]            s_axi_control_rresp,
  output logic                  regGoValid,
  input  logic                  regGoHoldoff,
  input  logic                  regDoneValid,
  output logic                  regDoneStop,
  output logic [64*ArgCount-1:0] kernelArgs,
  output logic                  interrupt
);

  logic                   r_bvalid;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic                   r_startPending;
  logic                   r_idle;
  logic                   r_doneFlag;
  logic                   r_gie;
  logic [1:0]             r_ier;
  logic [1:0]             r_isr;
  logic                   r_interrupt;

  logic                   w_wrAccept;
  logic                   w_rdAccept;
  logic [AddrWidth-1:0]   w_wrAddr;
  logic [AddrWidth-1:0]   w_rdAddr;
  logic                   w_ctrlWrite;
  logic                   w_startSet;
  logic                   w_goHs;
  logic                   w_doneHs;
  logic                   w_apCtrlRead;
  logic                   w_argWrEn;
  logic                   w_gieNext;
  logic [1:0]             w_ierNext;
  logic [1:0]             w_isrNext;
  logic [31:0]            w_apCtrl;
  logic [31:0]            w_rdMux;
  logic [64*ArgCount-1:0] w_kernelArgs;

  // Address and data must arrive together; a pending write response blocks
  // the next write so bvalid can never be lost.
  assign w_wrAccept = s_axi_control_awvalid & s_axi_control_wvalid & ~r_bvalid;
  assign w_rdAccept = s_axi_control_arvalid & ~r_rvalid;

  // The two low address bits are don't-care, so mask them before decoding.
  assign w_wrAddr = s_axi_control_awaddr & ~AddrWidth'(3);
  assign w_rdAddr = s_axi_control_araddr & ~AddrWidth'(3);

  assign w_ctrlWrite  = w_wrAccept & s_axi_control_wstrb[0];
  assign w_startSet   = w_ctrlWrite & (w_wrAddr == AddrWidth'(ApCtrlAddr))
                      & s_axi_control_wdata[ApStartBit] & r_idle;
  assign w_goHs       = r_startPending & ~regGoHoldoff;
  assign w_doneHs     = regDoneValid & ~r_doneFlag;
  assign w_apCtrlRead = w_rdAccept & (w_rdAddr == AddrWidth'(ApCtrlAddr));
  assign w_argWrEn    = w_wrAccept & r_idle;

  assign s_axi_control_awready = w_wrAccept;
  assign s_axi_control_wready  = w_wrAccept;
  assign s_axi_control_bvalid  = r_bvalid;
  assign s_axi_control_bresp   = RespOkay;
  assign s_axi_control_arready = ~r_rvalid;
  assign s_axi_control_rvalid  = r_rvalid;
  assign s_axi_control_rdata   = r_rdata;
  assign s_axi_control_rresp   = RespOkay;
  assign regGoValid            = r_startPending;
  assign regDoneStop           = r_doneFlag;
  assign interrupt             = r_interrupt;
  assign kernelArgs            = w_kernelArgs;

  // Kernel run state. A start only lands while idle and drops idle; a done
  // handshake raises idle again. If a start and a done coincide, the start
  // is the newer run so it keeps idle low. For doneFlag a new done beats the
  // clear-on-read so a completion is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_startPending <= 1'b0;
      r_idle         <= 1'b1;
      r_doneFlag     <= 1'b0;
    end else begin
      if (w_startSet)        r_startPending <= 1'b1;
      else if (w_goHs)       r_startPending <= 1'b0;

      if (w_startSet)        r_idle <= 1'b0;
      else if (w_doneHs)     r_idle <= 1'b1;

      if (w_doneHs)          r_doneFlag <= 1'b1;
      else if (w_apCtrlRead) r_doneFlag <= 1'b0;
    end
  end

  // Next values of the interrupt registers. ISR bits toggle on a host write
  // of 1, and a done handshake sets every bit whose IER enable is on, taking
  // priority over a simultaneous toggle.
  always_comb begin
    w_gieNext = r_gie;
    w_ierNext = r_ier;
    w_isrNext = r_isr;
    if (w_ctrlWrite) begin
      if (w_wrAddr == AddrWidth'(GieAddr)) w_gieNext = s_axi_control_wdata[0];
      if (w_wrAddr == AddrWidth'(IerAddr)) w_ierNext = s_axi_control_wdata[1:0];
      if (w_wrAddr == AddrWidth'(IsrAddr)) w_isrNext = r_isr ^ s_axi_control_wdata[1:0];
    end
    if (w_doneHs) w_isrNext = w_isrNext | r_ier;
  end

  // The interrupt is computed from the next-state values so it rises in the
  // same cycle that ISR is set by the done handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gie       <= 1'b0;
      r_ier       <= 2'b00;
      r_isr       <= 2'b00;
      r_interrupt <= 1'b0;
    end else begin
      r_gie       <= w_gieNext;
      r_ier       <= w_ierNext;
      r_isr       <= w_isrNext;
      r_interrupt <= w_gieNext & (|w_isrNext);
    end
  end

  // Write response: raised the cycle after the write lands, held until the
  // host takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
    end else if (w_wrAccept) begin
      r_bvalid <= 1'b1;
    end else if (s_axi_control_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // ap_ctrl view: ap_done and ap_ready both mirror doneFlag; auto_restart is
  // not supported and always reads back 0.
  always_comb begin
    w_apCtrl                 = '0;
    w_apCtrl[ApStartBit]     = r_startPending;
    w_apCtrl[ApDoneBit]      = r_doneFlag;
    w_apCtrl[ApIdleBit]      = r_idle;
    w_apCtrl[ApReadyBit]     = r_doneFlag;
    w_apCtrl[AutoRestartBit] = 1'b0;
  end

  // Read data selection; anything not decoded here reads as zero.
  always_comb begin
    w_rdMux = '0;
    if (w_rdAddr == AddrWidth'(ApCtrlAddr)) w_rdMux = w_apCtrl;
    if (w_rdAddr == AddrWidth'(GieAddr))    w_rdMux = {31'b0, r_gie};
    if (w_rdAddr == AddrWidth'(IerAddr))    w_rdMux = {30'b0, r_ier};
    if (w_rdAddr == AddrWidth'(IsrAddr))    w_rdMux = {30'b0, r_isr};
    for (int n = 0; n < ArgCount; n++) begin
      if (w_rdAddr == AddrWidth'(argLoAddr(n)))
        w_rdMux = w_kernelArgs[64*n +: 32];
      if (w_rdAddr == AddrWidth'(argLoAddr(n) + 4))
        w_rdMux = w_kernelArgs[64*n + 32 +: 32];
    end
  end

  // Read channel: data is captured at acceptance and held stable until the
  // host takes it, so it reflects state before any same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rdAccept) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdMux;
    end else if (s_axi_control_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // One argument register per kernel argument; writes are dropped while the
  // kernel is running so arguments stay stable for the whole run.
  for (genvar n = 0; n < ArgCount; n++) begin : g_arg
    logic w_hitLo;
    logic w_hitHi;
    assign w_hitLo = (w_wrAddr == AddrWidth'(argLoAddr(n)));
    assign w_hitHi = (w_wrAddr == AddrWidth'(argLoAddr(n) + 4));

    sda_kernel_arg_reg u_argReg (
      .clk      (clk),
      .rst      (rst),
      .i_wrEnLo (w_argWrEn & w_hitLo),
      .i_wrEnHi (w_argWrEn & w_hitHi),
      .i_wdata  (s_axi_control_wdata),
      .i_wstrb  (s_axi_control_wstrb),
      .o_value  (w_kernelArgs[64*n +: 64])
    );
  end

endmodule
